// File: rtl/array_0_6_access_if.sv
// Request/response channel bundle for array_0_6_access.
// Carries the valid/ready request channel and the valid/ready read-response channel.
// master = requester side (drives req_*, resp_ready); slave = the access block.
interface array_0_6_access_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 15
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/array_0_6_access.sv
// Purpose: request/response front-end for the 4096x15 single-port array macro (RW0 port).
// Latency: read accepted at edge N is captured at edge N+1 and visible after it; writes take 1 cycle.
// Backpressure: req_ready drops while FIFO entries plus the in-flight read fill RESP_DEPTH.
//
// Ports: clock/reset_n (async active-low); bus (slave modport) carries req_*/resp_*;
// init_done; sram_addr/sram_en/sram_wmode/sram_wdata to the macro, sram_rdata from it.
// Optional feature macro: SRAM_ZERO_INIT_EN -- after reset, walk the whole array writing 0
// before accepting requests. Undefined: no init walk, init_done is constant 1.
module array_0_6_access #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 15,
    parameter int RESP_DEPTH = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    array_0_6_access_if.slave    bus,
    output logic                 init_done,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic                 sram_en,
    output logic                 sram_wmode,
    output logic [DATA_W-1:0]    sram_wdata,
    input  logic [DATA_W-1:0]    sram_rdata
);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t LAST_PTR = ptr_t'(RESP_DEPTH - 1);

    logic [DATA_W-1:0] fifo_mem_q [RESP_DEPTH];
    logic [DATA_W-1:0] fifo_mem_d [RESP_DEPTH];
    ptr_t              head_q, head_d;
    ptr_t              tail_q, tail_d;
    cnt_t              count_q, count_d;
    logic              rd_inflight_q, rd_inflight_d;

    logic              accept;
    logic              push;
    logic              pop;
    logic              init_busy;
    logic [ADDR_W-1:0] init_addr;
    logic [CNT_W:0]    occupancy;

`ifdef SRAM_ZERO_INIT_EN
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_done_q, init_done_d;

    always_comb begin
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        if (!init_done_q) begin
            init_cnt_d = init_cnt_q + ADDR_W'(1);
            if (init_cnt_q == '1) begin
                init_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;
    // Gate with reset_n so the macro sees no enable while the block is held in reset.
    assign init_busy = reset_n && !init_done_q;
    assign init_addr = init_cnt_q;
`else
    assign init_done = 1'b1;
    assign init_busy = 1'b0;
    assign init_addr = '0;
`endif

    // Every accepted read owns a FIFO slot from acceptance, so overflow cannot occur.
    assign occupancy     = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_inflight_q};
    assign bus.req_ready = init_done && (int'(occupancy) < RESP_DEPTH);
    assign accept        = bus.req_valid && bus.req_ready;

    assign push           = rd_inflight_q;
    assign bus.resp_valid = (count_q != '0);
    assign pop            = bus.resp_valid && bus.resp_ready;
    assign bus.resp_rdata = fifo_mem_q[head_q];

    // Macro drive: init walk has priority (requests are blocked during it anyway).
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (init_busy) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_addr;
        end else if (accept) begin
            sram_en    = 1'b1;
            sram_wmode = bus.req_write;
            sram_addr  = bus.req_addr;
            sram_wdata = bus.req_wdata;
        end
    end

    always_comb begin
        rd_inflight_d = accept && !bus.req_write;
        fifo_mem_d    = fifo_mem_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        if (push) begin
            fifo_mem_d[tail_q] = sram_rdata;
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + ptr_t'(1);
        end
        if (pop) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + ptr_t'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            fifo_mem_q    <= fifo_mem_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end
endmodule

// File: tb/tb_array_0_6_access.sv
// Purpose: self-checking bench for array_0_6_access with a behavioural macro and reference model.
// Latency: one bench step per clock; outputs sampled 1 ns after the falling edge.
// Backpressure: resp_ready driven by directed phases and randomly; req_ready predicted by the model.
`timescale 1ns/1ps
module tb_array_0_6_access;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 15;
    localparam int DEPTH  = 3;
    localparam int NWORDS = 4096;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              init_done;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_en;
    logic              sram_wmode;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    always #5 clock = ~clock;

    array_0_6_access_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    array_0_6_access #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESP_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .init_done  (init_done),
        .sram_addr  (sram_addr),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Behavioural single-port macro: read data appears the cycle after the enable.
    logic [DATA_W-1:0] macro_mem [NWORDS];
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) macro_mem[sram_addr] <= sram_wdata;
            else            sram_rdata <= macro_mem[sram_addr];
        end
    end

    always @(posedge clock) begin
        if (reset_n) begin
            assert (!(dut.rd_inflight_q && int'(dut.count_q) == DEPTH &&
                      !(bus.resp_valid && bus.resp_ready)))
            else $error("FAIL fifo_overflow: push into full FIFO without pop");
        end
    end

    // Reference model: array contents plus an ordered list of expected responses,
    // each tagged with the cycle from which it becomes visible.
    typedef struct {
        logic [DATA_W-1:0] data;
        int                vis;
    } resp_t;

    int                errors = 0;
    int                checks = 0;
    int                cyc = 0;
    int                init_cnt = 0;
    logic [DATA_W-1:0] ref_mem [NWORDS];
    resp_t             exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_init_done();
`ifdef SRAM_ZERO_INIT_EN
        return init_cnt >= NWORDS;
`else
        return 1'b1;
`endif
    endfunction

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic step(input bit v, input bit w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit rr);
        bit m_init, m_rdy, m_vld, acc;
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.resp_ready = rr;
        #1;
        m_init = m_init_done();
        m_rdy  = m_init && (exp_q.size() < DEPTH);
        m_vld  = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
        acc    = v && m_rdy;
        check_eq("init_done", 32'(init_done), 32'(m_init));
        check_eq("req_ready", 32'(bus.req_ready), 32'(m_rdy));
        check_eq("resp_valid", 32'(bus.resp_valid), 32'(m_vld));
        if (m_vld) check_eq("resp_rdata", 32'(bus.resp_rdata), 32'(exp_q[0].data));
        if (!m_init) begin
            check_eq("init_en", 32'(sram_en), 32'd1);
            check_eq("init_wmode", 32'(sram_wmode), 32'd1);
            check_eq("init_addr", 32'(sram_addr), 32'(init_cnt));
            check_eq("init_wdata", 32'(sram_wdata), 32'd0);
        end else begin
            check_eq("sram_en", 32'(sram_en), 32'(acc));
            check_eq("sram_wmode", 32'(sram_wmode), acc ? 32'(w) : 32'd0);
            check_eq("sram_addr", 32'(sram_addr), acc ? 32'(a) : 32'd0);
            check_eq("sram_wdata", 32'(sram_wdata), acc ? 32'(d) : 32'd0);
        end
        @(posedge clock);
        if (m_vld && rr) void'(exp_q.pop_front());
        if (acc) begin
            if (w) ref_mem[a] = d;
            else   exp_q.push_back('{data: ref_mem[a], vis: cyc + 2});
        end
        if (!m_init) ref_mem[init_cnt] = '0;
        init_cnt++;
        cyc++;
        @(negedge clock);
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, rr);
    endtask

    // Issue one request and keep it up until the model says it was taken.
    task automatic send(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int  tries = 0;
        bit  taken = 1'b0;
        while (!taken && tries < 50) begin
            taken = m_init_done() && (exp_q.size() < DEPTH);
            step(1'b1, w, a, d, 1'b1);
            tries++;
        end
        check_eq("send_accepted", 32'(taken), 32'd1);
    endtask

    task automatic apply_reset(input int hold);
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
        check_eq("rst_sram_en", 32'(sram_en), 32'd0);
`ifdef SRAM_ZERO_INIT_EN
        check_eq("rst_init_done", 32'(init_done), 32'd0);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
`endif
        exp_q.delete();
        init_cnt = 0;
        repeat (hold) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
        @(negedge clock);
        apply_reset(3);

`ifdef SRAM_ZERO_INIT_EN
        // Abort the walk at cycle 100; the model expects it to restart at address 0.
        idle(100, 1'b1);
        apply_reset(2);
        idle(NWORDS, 1'b1);
        send(1'b0, 12'hFFF, '0);
        idle(3, 1'b1);
`endif

        // Preload addresses 0..63 with their own address.
        for (int i = 0; i < 64; i++) send(1'b1, ADDR_W'(i), DATA_W'(i));

        // Single write then read: 2-edge latency checked by the per-cycle model.
        send(1'b1, 12'h005, 15'h1234);
        send(1'b0, 12'h005, '0);
        idle(3, 1'b1);

        // 8 back-to-back reads, no bubbles expected.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, ADDR_W'(32 + i), '0, 1'b1);
        idle(3, 1'b1);

        // Backpressure: only 3 reads fit, then drain in order.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, ADDR_W'(40 + i), '0, 1'b0);
        check_eq("bp_ready_low", 32'(bus.req_ready), 32'd0);
        check_eq("bp_queued", 32'(exp_q.size()), 32'd3);
        idle(5, 1'b1);
        check_eq("bp_ready_back", 32'(bus.req_ready), 32'd1);

        // Read followed immediately by a write to the same address.
        send(1'b1, 12'h010, 15'h0AAA);
        step(1'b1, 1'b0, 12'h010, '0, 1'b1);
        step(1'b1, 1'b1, 12'h010, 15'h0555, 1'b1);
        step(1'b1, 1'b0, 12'h010, '0, 1'b1);
        idle(3, 1'b1);

        // Random traffic over the preloaded region.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ADDR_W'($urandom_range(0, 63)), DATA_W'($urandom), ($urandom_range(0, 2) != 0));
        end
        idle(4, 1'b1);

        // Reset with two responses pending; nothing stale may follow.
        step(1'b1, 1'b0, 12'h020, '0, 1'b0);
        step(1'b1, 1'b0, 12'h021, '0, 1'b0);
        idle(2, 1'b0);
        check_eq("pre_rst_pending", 32'(bus.resp_valid), 32'd1);
        apply_reset(2);
`ifdef SRAM_ZERO_INIT_EN
        idle(NWORDS, 1'b1);
`endif
        idle(6, 1'b1);
        send(1'b0, 12'h005, '0);
        idle(3, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
